// File: rtl/ip_hdr_preprocess_if.sv
// ip_hdr_preprocess_if
//   Bundles the datapath word stream into and out of the header pre-processor
//   together with the per-word strobes and the per-packet header summary.
//   master : the upstream producer / downstream consumer side (drives in_*).
//   slave  : the pre-processor itself (drives out_*, strobes and summary).
//
//   in_data/in_ctrl/in_wr     : incoming word, control byte, word valid
//   out_data/out_ctrl/out_wr  : the same, registered one cycle
//   word_*                    : one-cycle strobes for data words 0..4
//   hdr_info_vld + summary    : per-packet header summary pulse
interface ip_hdr_preprocess_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic [CTRL_WIDTH-1:0] in_ctrl;
    logic                  in_wr;

    logic [DATA_WIDTH-1:0] out_data;
    logic [CTRL_WIDTH-1:0] out_ctrl;
    logic                  out_wr;

    logic word_MAC_DA_SA;
    logic word_MAC_SA_ETHTYPE;
    logic word_IP_LEN_ID;
    logic word_IP_SRC_DST;
    logic word_IP_DST_LO;

    logic hdr_info_vld;
    logic is_ipv4;
    logic is_arp;
    logic ip_options;
    logic ttl_le_1;
    logic checksum_ok;
    logic truncated;

    modport master (
        output in_data, in_ctrl, in_wr,
        input  out_data, out_ctrl, out_wr,
        input  word_MAC_DA_SA, word_MAC_SA_ETHTYPE, word_IP_LEN_ID,
               word_IP_SRC_DST, word_IP_DST_LO,
        input  hdr_info_vld, is_ipv4, is_arp, ip_options, ttl_le_1,
               checksum_ok, truncated
    );

    modport slave (
        input  in_data, in_ctrl, in_wr,
        output out_data, out_ctrl, out_wr,
        output word_MAC_DA_SA, word_MAC_SA_ETHTYPE, word_IP_LEN_ID,
               word_IP_SRC_DST, word_IP_DST_LO,
        output hdr_info_vld, is_ipv4, is_arp, ip_options, ttl_le_1,
               checksum_ok, truncated
    );
endinterface

// File: rtl/ip_hdr_preprocess.sv
// ip_hdr_preprocess
//   Header-snooping stage on the 64-bit datapath. Registers the word stream
//   by one cycle, marks data words 0..4 with one-cycle strobes aligned to the
//   registered data, and produces one header summary pulse per packet
//   (including an IPv4 header checksum check) once the destination IP word
//   has passed, or earlier if the packet ends before it.
//
//   Ports: clk, reset (async, active-high), bus (ip_hdr_preprocess_if.slave).
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   MODULE_HDRS | between packets / skipping 0xFF module-header words
//   HDR         | inside header words 1..4, word_cnt holds next index
//   WAIT_EOP    | header fully seen, waiting for the last word
module ip_hdr_preprocess #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic             clk,
    input  logic             reset,
    ip_hdr_preprocess_if.slave bus
);

    typedef enum logic [1:0] {
        MODULE_HDRS = 2'd0,
        HDR         = 2'd1,
        WAIT_EOP    = 2'd2
    } state_t;

    localparam logic [CTRL_WIDTH-1:0] CTRL_MOD_HDR = '1;
    localparam logic [CTRL_WIDTH-1:0] CTRL_DATA    = '0;

    state_t      state, state_nxt;
    logic [2:0]  word_cnt, word_cnt_nxt;
    logic [19:0] acc, acc_nxt;

    // header fields captured as they go by, consumed at word 4
    logic eth_ipv4, eth_ipv4_nxt;
    logic eth_arp,  eth_arp_nxt;
    logic ihl_opt,  ihl_opt_nxt;
    logic ttl_low,  ttl_low_nxt;

    logic                  is_eop;
    logic                  is_hdr_word;
    logic [2:0]            idx;
    logic [4:0]            strobe_nxt;
    logic                  emit;
    logic [5:0]            sum_nxt;    // {ipv4, arp, options, ttl, cksum, trunc}
    logic [19:0]           hw_sum4;
    logic [19:0]           acc_w4;
    logic [16:0]           fold_s;
    logic [15:0]           fold_f;
    logic [DATA_WIDTH-1:0] d;

    assign d      = bus.in_data;
    assign is_eop = (bus.in_ctrl != CTRL_MOD_HDR) && (bus.in_ctrl != CTRL_DATA);

    assign hw_sum4 = {4'd0, d[63:48]} + {4'd0, d[47:32]}
                   + {4'd0, d[31:16]} + {4'd0, d[15:0]};

    // word 4 contributes only its top halfword, then the end-around carry
    // is folded twice so any carry out of the first fold is absorbed
    assign acc_w4 = acc + {4'd0, d[63:48]};
    assign fold_s = {1'b0, acc_w4[15:0]} + {13'd0, acc_w4[19:16]};
    assign fold_f = fold_s[15:0] + {15'd0, fold_s[16]};

    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        acc_nxt      = acc;
        eth_ipv4_nxt = eth_ipv4;
        eth_arp_nxt  = eth_arp;
        ihl_opt_nxt  = ihl_opt;
        ttl_low_nxt  = ttl_low;
        is_hdr_word  = 1'b0;
        idx          = word_cnt;
        strobe_nxt   = 5'd0;
        emit         = 1'b0;
        sum_nxt      = 6'd0;

        case (state)
            MODULE_HDRS: begin
                if (bus.in_wr && (bus.in_ctrl != CTRL_MOD_HDR)) begin
                    is_hdr_word = 1'b1;
                    idx         = 3'd0;
                end
            end
            HDR: begin
                if (bus.in_wr) begin
                    is_hdr_word = 1'b1;
                end
            end
            WAIT_EOP: begin
                if (bus.in_wr && is_eop) begin
                    state_nxt = MODULE_HDRS;
                end
            end
            default: state_nxt = MODULE_HDRS;
        endcase

        if (is_hdr_word) begin
            strobe_nxt = 5'd1 << idx;
            case (idx)
                3'd0: begin
                    acc_nxt      = 20'd0;
                    eth_ipv4_nxt = 1'b0;
                    eth_arp_nxt  = 1'b0;
                    ihl_opt_nxt  = 1'b0;
                    ttl_low_nxt  = 1'b0;
                    word_cnt_nxt = 3'd1;
                    state_nxt    = HDR;
                end
                3'd1: begin
                    acc_nxt      = acc + {4'd0, d[15:0]};
                    eth_arp_nxt  = (d[31:16] == 16'h0806);
                    eth_ipv4_nxt = (d[31:16] == 16'h0800) && (d[15:12] == 4'd4);
                    ihl_opt_nxt  = (d[11:8] != 4'd5);
                    word_cnt_nxt = 3'd2;
                end
                3'd2: begin
                    acc_nxt      = acc + hw_sum4;
                    ttl_low_nxt  = (d[15:8] <= 8'd1);
                    word_cnt_nxt = 3'd3;
                end
                3'd3: begin
                    acc_nxt      = acc + hw_sum4;
                    word_cnt_nxt = 3'd4;
                end
                default: begin
                    acc_nxt   = acc_w4;
                    state_nxt = WAIT_EOP;
                    emit      = 1'b1;
                    sum_nxt   = {eth_ipv4, eth_arp, ihl_opt, ttl_low,
                                 (fold_f == 16'hFFFF) && eth_ipv4 && !ihl_opt,
                                 1'b0};
                end
            endcase

            if (is_eop) begin
                state_nxt    = MODULE_HDRS;
                word_cnt_nxt = 3'd0;
                if (idx != 3'd4) begin
                    // short packet: only the ethertype class is trustworthy,
                    // and only once word 1 (possibly this word) has been seen
                    emit    = 1'b1;
                    sum_nxt = {1'b0, (idx != 3'd0) && eth_arp_nxt, 4'b0001};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                   <= MODULE_HDRS;
            word_cnt                <= 3'd0;
            acc                     <= 20'd0;
            eth_ipv4                <= 1'b0;
            eth_arp                 <= 1'b0;
            ihl_opt                 <= 1'b0;
            ttl_low                 <= 1'b0;
            bus.out_data            <= '0;
            bus.out_ctrl            <= '0;
            bus.out_wr              <= 1'b0;
            bus.word_MAC_DA_SA      <= 1'b0;
            bus.word_MAC_SA_ETHTYPE <= 1'b0;
            bus.word_IP_LEN_ID      <= 1'b0;
            bus.word_IP_SRC_DST     <= 1'b0;
            bus.word_IP_DST_LO      <= 1'b0;
            bus.hdr_info_vld        <= 1'b0;
            bus.is_ipv4             <= 1'b0;
            bus.is_arp              <= 1'b0;
            bus.ip_options          <= 1'b0;
            bus.ttl_le_1            <= 1'b0;
            bus.checksum_ok         <= 1'b0;
            bus.truncated           <= 1'b0;
        end else begin
            state                   <= state_nxt;
            word_cnt                <= word_cnt_nxt;
            acc                     <= acc_nxt;
            eth_ipv4                <= eth_ipv4_nxt;
            eth_arp                 <= eth_arp_nxt;
            ihl_opt                 <= ihl_opt_nxt;
            ttl_low                 <= ttl_low_nxt;
            bus.out_data            <= bus.in_data;
            bus.out_ctrl            <= bus.in_ctrl;
            bus.out_wr              <= bus.in_wr;
            bus.word_MAC_DA_SA      <= strobe_nxt[0];
            bus.word_MAC_SA_ETHTYPE <= strobe_nxt[1];
            bus.word_IP_LEN_ID      <= strobe_nxt[2];
            bus.word_IP_SRC_DST     <= strobe_nxt[3];
            bus.word_IP_DST_LO      <= strobe_nxt[4];
            bus.hdr_info_vld        <= emit;
            if (emit) begin
                {bus.is_ipv4, bus.is_arp, bus.ip_options, bus.ttl_le_1,
                 bus.checksum_ok, bus.truncated} <= sum_nxt;
            end
        end
    end

endmodule

// File: doc/ip_hdr_preprocess.md
# ip_hdr_preprocess

Header-snooping stage that sits on the 64-bit router datapath directly upstream of the destination-IP filter and the other header-lookup blocks. Tracks word position within each packet, emits one-cycle word strobes aligned with a registered copy of the data, and produces a per-packet header summary, including an IPv4 header checksum check, once the destination IP has been seen.

## Interface
- DATA_WIDTH, 64, datapath width; only 64 is supported.
- CTRL_WIDTH, DATA_WIDTH/8, control-byte width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- in_data  in  64  datapath word.
- in_ctrl  in  8  0xFF = module header; 0x00 = packet data; any other value = last word (EOP).
- in_wr  in  1  word valid this cycle; no backpressure.
- out_data  out  64  in_data registered one cycle.
- out_ctrl  out  8  in_ctrl registered one cycle.
- out_wr  out  1  in_wr registered one cycle.
- word_MAC_DA_SA, word_MAC_SA_ETHTYPE, word_IP_LEN_ID, word_IP_SRC_DST, word_IP_DST_LO  out  1 each  one-cycle strobes marking data words 0..4 on out_data.
- hdr_info_vld  out  1  one-cycle pulse; the summary bits below are valid only in this cycle.
- is_ipv4  out  1  ethertype 0x0800 and version 4.
- is_arp  out  1  ethertype 0x0806.
- ip_options  out  1  IHL != 5.
- ttl_le_1  out  1  TTL <= 1.
- checksum_ok  out  1  IPv4 header one's-complement sum equals 0xFFFF.
- truncated  out  1  EOP arrived before word 4.

## Operation
- FSM states: MODULE_HDRS, HDR (word counter 0..4), WAIT_EOP. Reset state is MODULE_HDRS.
- MODULE_HDRS:
  - in_wr with in_ctrl==0xFF: stay.
  - Any other in_ctrl: this word is word 0. Counter becomes 1 and state moves to HDR, or stays MODULE_HDRS if the word is also EOP.
- HDR: each in_wr word is word N (counter). Word 4 moves to WAIT_EOP. EOP on any word returns to MODULE_HDRS.
- WAIT_EOP: an EOP word returns to MODULE_HDRS.
- Cycles without in_wr change no state and assert no strobes.
- Fields, using the bit ranges of the word that carries them:
  - ethertype = word1[31:16]
  - version = word1[15:12]
  - IHL = word1[11:8]
  - TTL = word2[15:8]
  - dst IP = {word3[15:0], word4[63:48]}
- Checksum: 20-bit accumulator, cleared at word 0. It sums ten 16-bit halfwords:
  - word1[15:0]
  - word2, all four halfwords
  - word3, all four halfwords
  - word4[63:48]
- Checksum fold at word 4 (including word4's halfword): s = acc[15:0] + acc[19:16], then f = s[15:0] + s[16]. checksum_ok = (f == 16'hFFFF) && is_ipv4 && !ip_options. Otherwise 0.
- Truncated packet: EOP on word k < 4 pulses hdr_info_vld with truncated=1. In that pulse, is_ipv4, ip_options, ttl_le_1 and checksum_ok are all 0. is_arp reflects the ethertype if word 1 was seen, else 0. hdr_info_vld pulses exactly once per packet.
- EOP on word 4 itself is not truncated: the full summary is produced and the FSM goes to MODULE_HDRS.
- Reset mid-packet: all state clears immediately. The next non-0xFF word is treated as word 0.

## Timing
- All outputs are registered. Reset value of every output is 0, including out_data and out_ctrl.
- Latency: a word accepted at cycle t appears on out_data/out_ctrl/out_wr at t+1. Its word strobe is high at t+1 only.
- hdr_info_vld and the summary bits assert at t+1 after word 4, in the same cycle as word_IP_DST_LO. For a truncated packet they assert at t+1 after the EOP word.
- Summary bits hold their value until the next hdr_info_vld; consumers sample them only during the pulse.
- Back-to-back packets, including a new module header the cycle after EOP, need no idle cycles.

## Test plan
- **Valid IPv4 packet.** Stimulus: one 0xFF module header, then words:
  - word0: any
  - word1: SA lo, 0x0800, 0x4500
  - word2: 0x0073_0000_4000_4011
  - word3: 0xB861_C0A8_0001_C0A8
  - word4: 0x00C7_xxxx_xxxx_xxxx
  - then 3 more words, the last with ctrl 0x01.
  - Required: strobes on 5 consecutive cycles starting 1 cycle after word0. hdr_info_vld coincides with word_IP_DST_LO, with is_ipv4=1, checksum_ok=1, ttl_le_1=0, ip_options=0, truncated=0. Dst IP reconstructs as 0xC0A800C7.
- **Bad checksum.** Same packet with word3[63:48]=0xB862 -> checksum_ok=0, is_ipv4=1.
- **Summary edge cases.**
  - TTL=0x01 and IHL=6 -> ttl_le_1=1, ip_options=1, checksum_ok=0.
  - Ethertype 0x0806 -> is_arp=1, is_ipv4=0.
- **Truncated packet.** EOP (ctrl 0x04) on word 2 -> word_IP_SRC_DST and word_IP_DST_LO never assert. One hdr_info_vld with truncated=1.
- **Gaps and back-to-back.** in_wr deasserted randomly mid-header -> strobes still track word index correctly. Two back-to-back packets with zero idle -> two hdr_info_vld pulses with correct values.
- **Async reset.** Assert reset between word2 and word3 -> all outputs 0 immediately. After release, a fresh packet parses correctly.
